// File: rtl/scu_isa_pkg.sv
// SCU ISA definitions shared by the decode stage: opcodes, ALU operations,
// instruction field positions and the control-bundle decode helpers.
package scu_isa_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_SVPC = 4'b1111;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_NEG  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_BRZ  = 4'b1001;
   localparam logic [3:0] OP_JM   = 4'b1010;
   localparam logic [3:0] OP_BRN  = 4'b1011;

   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_NEG  = 4'd3;
   localparam logic [3:0] ALU_PASS = 4'd4;

   localparam int OPC_LSB = 28;
   localparam int OPC_W   = 4;
   localparam int RD_LSB  = 22;
   localparam int RS_LSB  = 16;
   localparam int RT_LSB  = 10;
   localparam int REG_W   = 6;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 16;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch_n;
      logic       branch_z;
      logic       jump;
      logic       jump_mem;
      logic       pc_to_reg;
      logic       load_store;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic [3:0] alu_op;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [3:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_NOP:  c = '0;
         OP_SVPC: begin c.reg_write = 1'b1; c.pc_to_reg = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
         OP_LD:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.mem_read = 1'b1;
                        c.load_store = 1'b1; c.alu_op = ALU_PASS; end
         OP_ST:   begin c.mem_write = 1'b1; c.load_store = 1'b1; c.alu_op = ALU_PASS; end
         OP_ADD:  begin c.reg_write = 1'b1; c.alu_op = ALU_ADD; end
         OP_INC:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
         OP_NEG:  begin c.reg_write = 1'b1; c.alu_op = ALU_NEG; end
         OP_SUB:  begin c.reg_write = 1'b1; c.alu_op = ALU_SUB; end
         OP_J:    c.jump = 1'b1;
         OP_BRZ:  c.branch_z = 1'b1;
         OP_JM:   begin c.jump_mem = 1'b1; c.mem_read = 1'b1; end
         OP_BRN:  c.branch_n = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   // Undefined opcodes behave as NOP and therefore read nothing.
   function automatic logic uses_rs(input logic [3:0] op);
      case (op)
         OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
         OP_J, OP_BRZ, OP_JM, OP_BRN: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rt(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ST: return 1'b1;
         default:               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/scu_id_stage_if.sv
// IF/ID-side inputs, writeback port and ID/EX-side outputs of the decode stage.
interface scu_id_stage_if;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        flush;
   logic        wb_we;
   logic [5:0]  wb_rd;
   logic [31:0] wb_data;
   logic        RegWrite, MemToReg, BranchN, BranchZ, Jump, JumpMem;
   logic        PCToReg, LoadStore, MemRead, MemWrite, ALUSrc;
   logic [3:0]  ALUOp;
   logic [31:0] pc_out;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] y;
   logic [5:0]  rd;
   logic        stall;

   modport master (
      output instr_in, pc_in, flush, wb_we, wb_rd, wb_data,
      input  RegWrite, MemToReg, BranchN, BranchZ, Jump, JumpMem,
             PCToReg, LoadStore, MemRead, MemWrite, ALUSrc, ALUOp,
             pc_out, rs_val, rt_val, y, rd, stall
   );

   modport slave (
      input  instr_in, pc_in, flush, wb_we, wb_rd, wb_data,
      output RegWrite, MemToReg, BranchN, BranchZ, Jump, JumpMem,
             PCToReg, LoadStore, MemRead, MemWrite, ALUSrc, ALUOp,
             pc_out, rs_val, rt_val, y, rd, stall
   );
endinterface

// File: rtl/scu_regfile.sv
// 64x32 register file: posedge write, two combinational read ports that
// return the writeback data when it targets the address being read.
module scu_regfile #(
   parameter int NREGS = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        we,
   input  logic [5:0]  wa,
   input  logic [31:0] wd,
   input  logic [5:0]  ra0,
   input  logic [5:0]  ra1,
   output logic [31:0] rd0,
   output logic [31:0] rd1
);
   logic [31:0] regs_q [NREGS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else if (we) begin
         regs_q[wa] <= wd;
      end
   end

   assign rd0 = (we && (wa == ra0)) ? wd : regs_q[ra0];
   assign rd1 = (we && (wa == ra1)) ? wd : regs_q[ra1];
endmodule

// File: rtl/scu_id_stage.sv
// SCU decode stage: control decode, operand read, immediate extension and
// RAW-hazard stalling against a scoreboard of in-flight destinations.
module scu_id_stage
   import scu_isa_pkg::*;
#(
   parameter int SB_DEPTH = 3,
   parameter int NREGS    = 64
) (
   input  logic           clock,
   input  logic           reset,
   scu_id_stage_if.slave  bus
);
   logic [3:0]       opcode;
   logic [REG_W-1:0] rd_f, rs_f, rt_f;
   ctrl_t            dec, ctrl;
   logic             hazard, stall, bubble;
   logic             sb_valid_d;
   logic             sb_valid_q [SB_DEPTH];
   logic [REG_W-1:0] sb_rd_q    [SB_DEPTH];

   assign opcode = bus.instr_in[OPC_LSB +: OPC_W];
   assign rd_f   = bus.instr_in[RD_LSB +: REG_W];
   assign rs_f   = bus.instr_in[RS_LSB +: REG_W];
   assign rt_f   = bus.instr_in[RT_LSB +: REG_W];
   assign dec    = decode_op(opcode);

   // The WB entry is skipped: the register file bypass already supplies it.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SB_DEPTH - 1; i++) begin
         hazard = hazard | (sb_valid_q[i] &
                  ((uses_rs(opcode) & (sb_rd_q[i] == rs_f)) |
                   (uses_rt(opcode) & (sb_rd_q[i] == rt_f))));
      end
   end

   assign stall      = ~reset & ~bus.flush & hazard;
   assign bubble     = reset | bus.flush | stall;
   assign sb_valid_d = dec.reg_write & ~stall & ~bus.flush;

   always_comb begin
      if (bubble) begin
         ctrl = '0;
      end else begin
         ctrl = dec;
      end
   end

   // Scoreboard shifts on the falling edge, in step with the ID/EX buffer.
   always_ff @(negedge clock) begin
      if (reset) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_valid_q[i] <= 1'b0;
            sb_rd_q[i]    <= 6'd0;
         end
      end else begin
         sb_valid_q[0] <= sb_valid_d;
         sb_rd_q[0]    <= rd_f;
         for (int i = 1; i < SB_DEPTH; i++) begin
            sb_valid_q[i] <= sb_valid_q[i-1];
            sb_rd_q[i]    <= sb_rd_q[i-1];
         end
      end
   end

   scu_regfile #(.NREGS(NREGS)) u_regfile (
      .clock (clock),
      .reset (reset),
      .we    (bus.wb_we),
      .wa    (bus.wb_rd),
      .wd    (bus.wb_data),
      .ra0   (rs_f),
      .ra1   (rt_f),
      .rd0   (bus.rs_val),
      .rd1   (bus.rt_val)
   );

   assign bus.RegWrite  = ctrl.reg_write;
   assign bus.MemToReg  = ctrl.mem_to_reg;
   assign bus.BranchN   = ctrl.branch_n;
   assign bus.BranchZ   = ctrl.branch_z;
   assign bus.Jump      = ctrl.jump;
   assign bus.JumpMem   = ctrl.jump_mem;
   assign bus.PCToReg   = ctrl.pc_to_reg;
   assign bus.LoadStore = ctrl.load_store;
   assign bus.MemRead   = ctrl.mem_read;
   assign bus.MemWrite  = ctrl.mem_write;
   assign bus.ALUSrc    = ctrl.alu_src;
   assign bus.ALUOp     = ctrl.alu_op;
   assign bus.pc_out    = bus.pc_in;
   assign bus.y         = {{(32-IMM_W){bus.instr_in[IMM_LSB+IMM_W-1]}}, bus.instr_in[IMM_LSB +: IMM_W]};
   assign bus.rd        = rd_f;
   assign bus.stall     = stall;
endmodule

// File: tb/tb_scu_id_stage.sv
// Self-checking bench for scu_id_stage: directed scenarios plus random traffic
// against a reference model of the ISA table, register file and in-flight window.
module tb_scu_id_stage;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   scu_id_stage_if bus();
   scu_id_stage #(.SB_DEPTH(3), .NREGS(64)) dut (.clock(clock), .reset(reset), .bus(bus));

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [14:0] C_RW  = 15'h4000, C_MTR = 15'h2000, C_BN = 15'h1000, C_BZ = 15'h0800;
   localparam logic [14:0] C_J   = 15'h0400, C_JM  = 15'h0200, C_PCR = 15'h0100, C_LS = 15'h0080;
   localparam logic [14:0] C_MR  = 15'h0040, C_MW  = 15'h0020, C_AS  = 15'h0010;

   function automatic logic [14:0] spec_ctrl(input logic [3:0] op);
      case (op)
         4'hF:    return C_RW | C_PCR | C_AS | 15'd1;
         4'hE:    return C_RW | C_MTR | C_MR | C_LS | 15'd4;
         4'h3:    return C_MW | C_LS | 15'd4;
         4'h4:    return C_RW | 15'd1;
         4'h5:    return C_RW | C_AS | 15'd1;
         4'h6:    return C_RW | 15'd3;
         4'h7:    return C_RW | 15'd2;
         4'h8:    return C_J;
         4'h9:    return C_BZ;
         4'hA:    return C_JM | C_MR;
         4'hB:    return C_BN;
         default: return 15'd0;
      endcase
   endfunction

   function automatic bit spec_uses_rs(input logic [3:0] op);
      return op inside {4'hE, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
   endfunction

   function automatic bit spec_uses_rt(input logic [3:0] op);
      return op inside {4'h4, 4'h7, 4'h3};
   endfunction

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] d, input logic [5:0] s,
                                      input logic [5:0] t, input logic [9:0] lo);
      return {op, d, s, t, lo};
   endfunction

   logic [14:0] act_ctrl;
   assign act_ctrl = {bus.RegWrite, bus.MemToReg, bus.BranchN, bus.BranchZ, bus.Jump, bus.JumpMem,
                      bus.PCToReg, bus.LoadStore, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.ALUOp};

   // Reference state: register contents and destinations issued in recent cycles
   // (index 0 = most recent, -1 = no write).
   logic [31:0] m_regs [64];
   int          pend_q [$];
   logic [14:0] e_ctrl;
   logic        e_stall;
   logic [31:0] e_rs, e_rt, e_y, e_pc;
   logic [5:0]  e_rd;

   task automatic model_expect();
      logic [3:0] op;
      int rs, rt, imm;
      bit hz;
      op  = bus.instr_in[31:28];
      rs  = int'(bus.instr_in[21:16]);
      rt  = int'(bus.instr_in[15:10]);
      hz  = 1'b0;
      for (int i = 0; i < 2 && i < pend_q.size(); i++) begin
         if (pend_q[i] >= 0 && ((spec_uses_rs(op) && pend_q[i] == rs) || (spec_uses_rt(op) && pend_q[i] == rt)))
            hz = 1'b1;
      end
      e_stall = !reset && !bus.flush && hz;
      e_ctrl  = (reset || bus.flush || e_stall) ? 15'd0 : spec_ctrl(op);
      e_rs    = (bus.wb_we && int'(bus.wb_rd) == rs) ? bus.wb_data : m_regs[rs];
      e_rt    = (bus.wb_we && int'(bus.wb_rd) == rt) ? bus.wb_data : m_regs[rt];
      imm     = int'(bus.instr_in[15:0]);
      if (imm >= 32768) imm = imm - 65536;
      e_y     = imm;
      e_rd    = bus.instr_in[27:22];
   endtask

   task automatic drive(input logic [31:0] instr, input logic fl, input logic we,
                        input logic [5:0] wrd, input logic [31:0] wd);
      bus.instr_in = instr;
      bus.pc_in    = $urandom;
      e_pc         = bus.pc_in;
      bus.flush    = fl;
      bus.wb_we    = we;
      bus.wb_rd    = wrd;
      bus.wb_data  = wd;
      #1;
      model_expect();
   endtask

   task automatic advance();
      @(negedge clock);
      if (reset) pend_q.delete();
      else begin
         pend_q.push_front(e_ctrl[14] ? int'(bus.instr_in[27:22]) : -1);
         if (pend_q.size() > 3) void'(pend_q.pop_back());
      end
      @(posedge clock);
      if (reset) foreach (m_regs[i]) m_regs[i] = 32'd0;
      else if (bus.wb_we) m_regs[bus.wb_rd] = bus.wb_data;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin drive(32'h0, 1'b0, 1'b0, 6'd0, 32'd0); advance(); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive((c == 0) ? 32'h0 : 32'h50C1FFFE, 1'b0, 1'b0, 6'd0, 32'd0);
         n_cmp++; if (act_ctrl !== 15'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0000", act_ctrl); end
         n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
         advance();
      end
      reset = 1'b0;
      for (int r = 0; r < 64; r += 21) begin
         drive(mk(4'h0, 6'd0, 6'(r), 6'(63 - r), 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
         n_cmp++; if (bus.rs_val !== 32'd0) begin n_fail++; $display("FAIL reset_reg rs r%0d: got %h want 0", r, bus.rs_val); end
         n_cmp++; if (bus.rt_val !== 32'd0) begin n_fail++; $display("FAIL reset_reg rt r%0d: got %h want 0", 63 - r, bus.rt_val); end
         n_cmp++; if (act_ctrl !== 15'd0 || bus.stall !== 1'b0) begin n_fail++;
            $display("FAIL nop_ctrl: got %h/%b want 0000/0", act_ctrl, bus.stall); end
         advance();
      end
   endtask

   task automatic test_decode();
      drive(32'h50C1FFFE, 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (act_ctrl !== (C_RW | C_AS | 15'd1)) begin n_fail++; $display("FAIL inc_ctrl: got %h want %h", act_ctrl, C_RW | C_AS | 15'd1); end
      n_cmp++; if (bus.y !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL inc_y: got %h want fffffffe", bus.y); end
      n_cmp++; if (bus.rd !== 6'd3) begin n_fail++; $display("FAIL inc_rd: got %0d want 3", bus.rd); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL inc_stall: got %b want 0", bus.stall); end
      advance();
      for (int op = 0; op < 16; op++) begin
         drive(mk(4'(op), 6'($urandom_range(32, 63)), 6'($urandom_range(32, 63)), 6'($urandom_range(32, 63)),
                  10'($urandom)), 1'b0, 1'b0, 6'd0, 32'd0);
         n_cmp++; if (act_ctrl !== e_ctrl || bus.stall !== e_stall) begin n_fail++;
            $display("FAIL decode op%0h: got %h/%b want %h/%b", op, act_ctrl, bus.stall, e_ctrl, e_stall); end
         n_cmp++; if (bus.y !== e_y || bus.rd !== e_rd) begin n_fail++;
            $display("FAIL decode_fields op%0h: got y=%h rd=%0d want y=%h rd=%0d", op, bus.y, bus.rd, e_y, e_rd); end
         advance();
      end
   endtask

   task automatic test_write_through();
      drive(mk(4'h0, 6'd0, 6'd5, 6'd5, 10'd0), 1'b0, 1'b1, 6'd5, 32'h1234);
      n_cmp++; if (bus.rs_val !== 32'h1234 || bus.rt_val !== 32'h1234) begin n_fail++;
         $display("FAIL wt_bypass: got %h/%h want 00001234", bus.rs_val, bus.rt_val); end
      advance();
      drive(mk(4'h0, 6'd0, 6'd5, 6'd63, 10'd0), 1'b0, 1'b1, 6'd63, 32'hCAFE0063);
      n_cmp++; if (bus.rs_val !== 32'h1234) begin n_fail++; $display("FAIL wt_stored: got %h want 00001234", bus.rs_val); end
      n_cmp++; if (bus.rt_val !== 32'hCAFE0063) begin n_fail++; $display("FAIL wt_r63: got %h want cafe0063", bus.rt_val); end
      advance();
      drive(mk(4'h0, 6'd0, 6'd63, 6'd0, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (bus.rs_val !== 32'hCAFE0063) begin n_fail++; $display("FAIL wt_r63_stored: got %h want cafe0063", bus.rs_val); end
      advance();
   endtask

   task automatic test_raw_stall();
      int n_st;
      drain();
      drive(mk(4'h4, 6'd1, 6'd2, 6'd3, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (act_ctrl !== (C_RW | 15'd1) || bus.stall !== 1'b0) begin n_fail++;
         $display("FAIL raw_first: got %h/%b want %h/0", act_ctrl, bus.stall, C_RW | 15'd1); end
      advance();
      n_st = 0;
      for (int c = 0; c < 6; c++) begin
         drive(mk(4'h4, 6'd4, 6'd1, 6'd1, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
         n_cmp++; if (bus.stall !== e_stall) begin n_fail++; $display("FAIL raw_stall c%0d: got %b want %b", c, bus.stall, e_stall); end
         if (bus.stall !== 1'b1) break;
         n_st++;
         n_cmp++; if (act_ctrl !== 15'd0) begin n_fail++; $display("FAIL raw_bubble: got %h want 0000", act_ctrl); end
         advance();
      end
      n_cmp++; if (n_st != 2) begin n_fail++; $display("FAIL raw_stall_len: got %0d want 2", n_st); end
      n_cmp++; if (bus.RegWrite !== 1'b1) begin n_fail++; $display("FAIL raw_issue: RegWrite got %b want 1", bus.RegWrite); end
      advance();
   endtask

   task automatic test_rt_unused();
      int n_st;
      drain();
      drive(mk(4'h5, 6'd1, 6'd0, 6'd0, 10'd1), 1'b0, 1'b0, 6'd0, 32'd0); advance();
      drive(mk(4'h5, 6'd2, 6'd0, 6'd0, 10'd1), 1'b0, 1'b0, 6'd0, 32'd0); advance();
      n_st = 0;
      for (int c = 0; c < 5; c++) begin
         drive(mk(4'h6, 6'd6, 6'd1, 6'd2, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
         if (bus.stall !== 1'b1) break;
         n_st++;
         advance();
      end
      n_cmp++; if (n_st != 1) begin n_fail++; $display("FAIL neg_rt_unused: stall cycles got %0d want 1", n_st); end
      n_cmp++; if (act_ctrl !== (C_RW | 15'd3)) begin n_fail++; $display("FAIL neg_issue: got %h want %h", act_ctrl, C_RW | 15'd3); end
      advance();
      drain();
      drive(mk(4'h5, 6'd7, 6'd0, 6'd0, 10'd1), 1'b0, 1'b0, 6'd0, 32'd0); advance();
      drive(mk(4'h8, 6'd0, 6'd0, 6'd7, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (bus.stall !== 1'b0 || act_ctrl !== C_J) begin n_fail++;
         $display("FAIL j_rt_unused: got %h/%b want %h/0", act_ctrl, bus.stall, C_J); end
      advance();
   endtask

   task automatic test_flush();
      drain();
      drive(mk(4'h5, 6'd9, 6'd0, 6'd0, 10'd1), 1'b0, 1'b0, 6'd0, 32'd0); advance();
      drive(mk(4'h4, 6'd10, 6'd9, 6'd9, 10'd0), 1'b1, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (bus.stall !== 1'b0 || act_ctrl !== 15'd0) begin n_fail++;
         $display("FAIL flush_prio: got %h/%b want 0000/0", act_ctrl, bus.stall); end
      advance();
      drive(mk(4'h3, 6'd0, 6'd10, 6'd10, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (bus.stall !== 1'b0 || act_ctrl !== (C_MW | C_LS | 15'd4)) begin n_fail++;
         $display("FAIL flush_invalid_entry: got %h/%b want %h/0", act_ctrl, bus.stall, C_MW | C_LS | 15'd4); end
      advance();
   endtask

   task automatic test_reset_mid_stall();
      drain();
      drive(mk(4'h5, 6'd11, 6'd0, 6'd0, 10'd1), 1'b0, 1'b0, 6'd0, 32'd0); advance();
      drive(mk(4'h4, 6'd12, 6'd11, 6'd11, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL mid_stall_pre: got %b want 1", bus.stall); end
      advance();
      reset = 1'b1;
      drive(mk(4'h4, 6'd12, 6'd11, 6'd11, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (bus.stall !== 1'b0 || act_ctrl !== 15'd0) begin n_fail++;
         $display("FAIL mid_stall_reset: got %h/%b want 0000/0", act_ctrl, bus.stall); end
      advance();
      reset = 1'b0;
      drive(mk(4'h4, 6'd12, 6'd11, 6'd11, 10'd0), 1'b0, 1'b0, 6'd0, 32'd0);
      n_cmp++; if (bus.stall !== 1'b0 || act_ctrl !== (C_RW | 15'd1)) begin n_fail++;
         $display("FAIL mid_stall_after: got %h/%b want %h/0", act_ctrl, bus.stall, C_RW | 15'd1); end
      advance();
   endtask

   task automatic test_random();
      logic [31:0] instr;
      bit hold;
      hold  = 1'b0;
      instr = 32'h0;
      for (int c = 0; c < 400; c++) begin
         if (!hold) instr = mk(4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                               6'($urandom_range(0, 7)), 10'($urandom));
         drive(instr, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
         n_cmp++; if (act_ctrl !== e_ctrl || bus.stall !== e_stall) begin n_fail++;
            $display("FAIL rand_ctrl c%0d instr=%h: got %h/%b want %h/%b", c, instr, act_ctrl, bus.stall, e_ctrl, e_stall); end
         n_cmp++; if (bus.rs_val !== e_rs || bus.rt_val !== e_rt) begin n_fail++;
            $display("FAIL rand_operands c%0d: got %h/%h want %h/%h", c, bus.rs_val, bus.rt_val, e_rs, e_rt); end
         n_cmp++; if (bus.y !== e_y || bus.rd !== e_rd || bus.pc_out !== e_pc) begin n_fail++;
            $display("FAIL rand_fields c%0d: got y=%h rd=%0d pc=%h want y=%h rd=%0d pc=%h", c, bus.y, bus.rd, bus.pc_out, e_y, e_rd, e_pc); end
         hold = e_stall;
         advance();
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.instr_in = 32'h0;
      bus.pc_in    = 32'h0;
      bus.flush    = 1'b0;
      bus.wb_we    = 1'b0;
      bus.wb_rd    = 6'd0;
      bus.wb_data  = 32'h0;
      @(posedge clock); #1;
      test_reset();
      test_decode();
      test_write_through();
      test_raw_stall();
      test_rt_unused();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/scu_id_stage.md
Name: scu_id_stage

Overview:
Instruction-decode stage of the SCU pipelined CPU, directly upstream of the ID/EX buffer. It decodes the IF/ID instruction into the control bundle, reads two operands from a 64x32 register file, and sign-extends the immediate. A 3-entry in-flight destination scoreboard detects RAW hazards, since the pipeline has no forwarding. On a hazard it stalls IF/ID and the PC, and injects a bubble into ID/EX.

Parameters:
SB_DEPTH, 3, number of in-flight stages tracked (EX, MEM, WB); entry SB_DEPTH-1 is the WB stage
NREGS, 64, register file depth (6-bit specifiers)

Ports:
clock  in  1  system clock
reset  in  1  reset
instr_in  in  32  instruction from IF/ID
pc_in  in  32  PC from IF/ID
flush  in  1  branch/jump taken in EX; kill the instruction currently in ID
wb_we  in  1  writeback enable
wb_rd  in  6  writeback register
wb_data  in  32  writeback data
RegWrite, MemToReg, BranchN, BranchZ, Jump, JumpMem, PCToReg, LoadStore, MemRead, MemWrite, ALUSrc  out  1 each  control bundle to ID/EX
ALUOp  out  4  ALU operation
pc_out  out  32  pc_in passthrough
rs_val, rt_val  out  32  operand values
y  out  32  sign-extended instr_in[15:0]
rd  out  6  instr_in[27:22]
stall  out  1  freeze PC and IF/ID

Behaviour:
- Reset: synchronous, active-high. It clears all 64 registers and all scoreboard entries at the next active edge. While reset is high, every control output is 0 (bubble) and stall=0.
- Instruction fields: opcode [31:28], rd [27:22], rs [21:16], rt [15:10], imm [15:0].
- Decode (all control bits not listed are 0):
  - NOP 0000: none.
  - SVPC 1111: RegWrite, PCToReg, ALUSrc, ALUOp=ADD.
  - LD 1110: RegWrite, MemToReg, MemRead, LoadStore, ALUOp=PASS.
  - ST 0011: MemWrite, LoadStore, ALUOp=PASS.
  - ADD 0100: RegWrite, ALUOp=ADD.
  - INC 0101: RegWrite, ALUSrc, ALUOp=ADD.
  - NEG 0110: RegWrite, ALUOp=NEG.
  - SUB 0111: RegWrite, ALUOp=SUB.
  - J 1000: Jump.
  - BRZ 1001: BranchZ.
  - JM 1010: JumpMem, MemRead.
  - BRN 1011: BranchN.
  - Undefined opcodes decode as NOP.
- Source usage:
  - rs is used by every opcode except NOP and SVPC.
  - rt is used only by ADD, SUB and ST.
- Register file:
  - Writes on posedge clock when wb_we=1; all 64 registers are writable.
  - Reads are combinational.
  - Write-through bypass: if wb_we and wb_rd equals the read address, the read returns wb_data.
- Scoreboard:
  - Entry i holds {valid, rd}.
  - Advances on negedge clock, in lockstep with the ID/EX buffer.
  - On each advance, entry[i+1] <= entry[i]; entry[0] <= {RegWrite & ~stall & ~flush, rd}.
- Hazard detection:
  - stall = ~reset & ~flush & (some used source equals rd of a valid entry 0..SB_DEPTH-2).
  - The WB entry is never compared, because the write-through bypass covers it.
  - With default depth, a back-to-back dependence stalls exactly 2 cycles.
- Bubble: when stall or flush is high, all control outputs are forced to 0 and ALUOp to 0. Data outputs may carry don't-care values but remain deterministic.
- Simultaneous flush and hazard: flush wins, stall=0, and a bubble is emitted.
- Latency: purely combinational from instr_in to the outputs. Only the register file and the scoreboard hold state.
- Reset mid-stall: the scoreboard clears, so stall falls to 0 on the following cycle.

Decomposition:
- Package scu_isa_pkg holds:
  - opcode localparams: OP_NOP, OP_SVPC, OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_J, OP_BRZ, OP_JM, OP_BRN.
  - ALUOp constants: ALU_NOP=0, ALU_ADD=1, ALU_SUB=2, ALU_NEG=3, ALU_PASS=4.
  - Field bit-position constants.
- Sub-module scu_regfile: 64x32 registers, posedge write, two combinational read ports with write-through, synchronous reset.
- The scoreboard and decode logic stay inline.

Test Plan:
- Reset then NOP: reset high for 2 cycles, then instr=0x00000000 -> all controls 0, stall=0; reading any register returns 0.
- Decode and immediate: INC r3,r1,#-2 (instr 0x50C1FFFE) -> RegWrite=1, ALUSrc=1, ALUOp=1, rd=3, y=0xFFFFFFFE, stall=0.
- Write-through: wb_we=1, wb_rd=5, wb_data=0x1234 while instr reads rs=5 -> rs_val=0x1234 in the same cycle; after the posedge, a read without wb_we also returns 0x1234.
- RAW stall: ADD r1,r2,r3 followed by ADD r4,r1,r1 -> stall=1 for exactly 2 cycles with bubble controls, then the dependent instruction issues with RegWrite=1.
- Non-use of rt: NEG r6,r1 after a write to r1, with rt field equal to a pending rd -> stall only for the rs match; a J whose rt field matches a pending rd -> no stall.
- Flush priority: a hazard is present and flush=1 -> stall=0, all controls 0, and the scoreboard enters an invalid entry at the next negedge.
